// File: rtl/fsm_ctx_sched.sv
// rtl/fsm_ctx_sched.sv - round-robin context scheduler sharing one 2-bit Mealy core across NCH channels
// Optional out_ready backpressure is enabled by defining FSM_CTX_SCHED_BACKPRESSURE_EN.
module fsm_ctx_sched #(
  parameter int NCH = 4,
  parameter int CW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [2*NCH-1:0] sym,
  input  logic [NCH-1:0]   ctx_clr,
`ifdef FSM_CTX_SCHED_BACKPRESSURE_EN
  input  logic             out_ready,
`endif
  output logic [NCH-1:0]   gnt,
  output logic [1:0]       core_s,
  output logic [1:0]       core_i,
  input  logic [1:0]       core_n,
  input  logic [1:0]       core_y,
  output logic             out_valid,
  output logic [CW-1:0]    out_ch,
  output logic [1:0]       out_y
);

  typedef enum logic {ARB, EXEC} state_t;

  state_t        state, state_nx;
  logic [1:0]    ctx [NCH];
  logic [CW-1:0] rr_ptr, cur_ch, win_ch, ptr_nx;
  logic [1:0]    cur_sym, win_sym, cur_ctx;
  logic          found, take, done, can_finish;
  int            arb_w, arb_best, arb_dist;

`ifdef FSM_CTX_SCHED_BACKPRESSURE_EN
  assign can_finish = out_ready;
`else
  assign can_finish = 1'b1;
`endif

  // Winner is the requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    found    = 1'b0;
    arb_w    = 0;
    arb_best = NCH;
    arb_dist = 0;
    for (int k = 0; k < NCH; k++) begin
      arb_dist = k - int'(rr_ptr);
      if (arb_dist < 0) arb_dist = arb_dist + NCH;
      if (req[k] && arb_dist < arb_best) begin
        arb_best = arb_dist;
        arb_w    = k;
        found    = 1'b1;
      end
    end
    win_ch  = CW'(arb_w);
    ptr_nx  = (arb_w == NCH - 1) ? '0 : CW'(arb_w + 1);
    win_sym = 2'b00;
    for (int k = 0; k < NCH; k++) begin
      if (arb_w == k) win_sym = sym[2*k +: 2];
    end
  end

  always_comb begin
    cur_ctx = 2'b00;
    for (int k = 0; k < NCH; k++) begin
      if (cur_ch == CW'(k)) cur_ctx = ctx[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    gnt      = '0;
    core_s   = 2'b00;
    core_i   = 2'b00;
    take     = 1'b0;
    done     = 1'b0;
    case (state)
      ARB: begin
        if (found) begin
          take     = 1'b1;
          state_nx = EXEC;
          for (int k = 0; k < NCH; k++) gnt[k] = (arb_w == k);
        end
      end
      EXEC: begin
        core_s = cur_ctx;
        core_i = cur_sym;
        if (can_finish) begin
          done     = 1'b1;
          state_nx = ARB;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cur_ch    <= '0;
      cur_sym   <= 2'b00;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= 2'b00;
      for (int k = 0; k < NCH; k++) ctx[k] <= 2'b00;
    end else begin
      out_valid <= done;
      if (take) begin
        cur_ch  <= win_ch;
        cur_sym <= win_sym;
        rr_ptr  <= ptr_nx;
      end
      if (done) begin
        out_ch <= cur_ch;
        out_y  <= core_y;
      end
      // A clear on the writeback edge wins over the core's next state.
      for (int k = 0; k < NCH; k++) begin
        if (ctx_clr[k])                         ctx[k] <= 2'b00;
        else if (done && cur_ch == CW'(k))      ctx[k] <= core_n;
      end
    end
  end

endmodule

// File: tb/tb_fsm_ctx_sched.sv
// tb/tb_fsm_ctx_sched.sv - self-checking bench for fsm_ctx_sched: directed table, round-robin run, random vs reference model
module tb_fsm_ctx_sched;

  localparam int NCH = 4;
  localparam int CW  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   req = '0;
  logic [2*NCH-1:0] sym = '0;
  logic [NCH-1:0]   ctx_clr = '0;
  logic             out_ready = 1'b1;
  logic [NCH-1:0]   gnt;
  logic [1:0]       core_s, core_i, core_n, core_y;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic [1:0]       out_y;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fsm_ctx_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .sym(sym), .ctx_clr(ctx_clr),
`ifdef FSM_CTX_SCHED_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .gnt(gnt), .core_s(core_s), .core_i(core_i), .core_n(core_n), .core_y(core_y),
    .out_valid(out_valid), .out_ch(out_ch), .out_y(out_y)
  );

  // Shared Mealy core: next = i ^ {s[1],0}, out = gray2bin(i) ^ s.
  function automatic logic [1:0] f_n(input logic [1:0] s, input logic [1:0] i);
    return i ^ {s[1], 1'b0};
  endfunction
  function automatic logic [1:0] f_y(input logic [1:0] s, input logic [1:0] i);
    return {i[1], i[1] ^ i[0]} ^ s;
  endfunction

  assign core_n = f_n(core_s, core_i);
  assign core_y = f_y(core_s, core_i);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] sym;
    logic [3:0] clr;
    int         chk;
    logic [3:0] gnt;
    logic [1:0] cs;
    logic [1:0] ci;
    logic       vld;
    logic [2:0] ch;
    logic [1:0] y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [3:0] rq, input logic [7:0] sy,
                             input logic [3:0] cl, input int c, input logic [3:0] g,
                             input logic [1:0] cs, input logic [1:0] ci, input logic vl,
                             input logic [2:0] ch, input logic [1:0] y);
    vec_t t;
    t.rst = r; t.req = rq; t.sym = sy; t.clr = cl; t.chk = c;
    t.gnt = g; t.cs = cs; t.ci = ci; t.vld = vl; t.ch = ch; t.y = y;
    return t;
  endfunction

  // Reference model state: one shared engine, per-channel contexts, rotating priority.
  logic [1:0] m_ctx [NCH];
  int         m_ptr, m_ch, m_w;
  logic       m_busy, m_ov;
  logic [1:0] m_sym, m_oy;
  int         m_och;

  task automatic model_reset();
    m_ptr = 0; m_ch = 0; m_busy = 1'b0; m_ov = 1'b0; m_sym = 2'b00; m_oy = 2'b00; m_och = 0;
    for (int k = 0; k < NCH; k++) m_ctx[k] = 2'b00;
  endtask

  task automatic model_pick();
    m_w = -1;
    if (!m_busy)
      for (int j = 0; j < NCH; j++)
        if (m_w < 0 && req[(m_ptr + j) % NCH]) m_w = (m_ptr + j) % NCH;
  endtask

  task automatic model_edge();
    logic rdy;
    rdy = 1'b1;
`ifdef FSM_CTX_SCHED_BACKPRESSURE_EN
    rdy = out_ready;
`endif
    if (rst) begin
      model_reset();
    end else begin
      m_ov = 1'b0;
      if (m_busy) begin
        if (rdy) begin
          m_oy  = f_y(m_ctx[m_ch], m_sym);
          m_och = m_ch;
          m_ov  = 1'b1;
          m_ctx[m_ch] = f_n(m_ctx[m_ch], m_sym);
          m_busy = 1'b0;
        end
      end else if (m_w >= 0) begin
        m_busy = 1'b1;
        m_ch   = m_w;
        m_sym  = sym[2*m_w +: 2];
        m_ptr  = (m_w + 1) % NCH;
      end
      for (int k = 0; k < NCH; k++) if (ctx_clr[k]) m_ctx[k] = 2'b00;
    end
  endtask

  initial begin
    logic [3:0] hold;
    logic [3:0] e_gnt;

    //            rst req   sym    clr chk gnt cs ci vld ch y
    tbl.push_back(v(1, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 4'h0, 8'h00, 0, 2, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(v(0, 4'h0, 8'h00, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 8'h01, 0, 1, 4'h1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h01, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 8'h02, 0, 1, 4'h1, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 4'h0, 8'h02, 0, 1, 4'h0, 1, 2, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 1, 4'h0, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 4'h0, 8'h00, 1, 1, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 8'h03, 0, 1, 4'h1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h03, 0, 1, 4'h0, 0, 3, 0, 0, 0));
    tbl.push_back(v(0, 4'h5, 8'h33, 0, 1, 4'h4, 0, 0, 1, 0, 2));
    tbl.push_back(v(0, 4'h1, 8'h33, 0, 1, 4'h0, 0, 3, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 8'h33, 0, 1, 4'h1, 0, 0, 1, 2, 2));
    tbl.push_back(v(0, 4'h0, 8'h33, 0, 1, 4'h0, 3, 3, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 1, 4'h0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 4'h2, 8'h0C, 0, 1, 4'h2, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h0C, 2, 1, 4'h0, 0, 3, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 1, 4'h0, 0, 0, 1, 1, 2));
    tbl.push_back(v(0, 4'h2, 8'h04, 0, 1, 4'h2, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h04, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 1, 4'h0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 4'h8, 8'hC0, 0, 1, 4'h8, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'hC0, 0, 1, 4'h0, 0, 3, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 1, 4'h0, 0, 0, 1, 3, 2));
    tbl.push_back(v(0, 4'h8, 8'h40, 0, 1, 4'h8, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 4'h0, 8'h40, 0, 1, 4'h0, 3, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 2, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'hA, 8'h44, 0, 1, 4'h2, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'h8, 8'h44, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h8, 8'h44, 0, 1, 4'h8, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 4'h0, 8'h44, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 1, 4'h0, 0, 0, 1, 3, 1));

    step();
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; sym = tbl[i].sym; ctx_clr = tbl[i].clr;
      @(negedge clk);
      if (tbl[i].chk != 0) begin
        chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
        chk($sformatf("row%0d core_s", i), 32'(core_s), 32'(tbl[i].cs));
        chk($sformatf("row%0d core_i", i), 32'(core_i), 32'(tbl[i].ci));
        chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
        if (tbl[i].chk == 2 || tbl[i].vld) begin
          chk($sformatf("row%0d out_ch", i), 32'(out_ch), 32'(tbl[i].ch));
          chk($sformatf("row%0d out_y", i), 32'(out_y), 32'(tbl[i].y));
        end
      end
      step();
    end

    // Full load: one grant every two cycles in strict rotation from pointer 0.
    req = 4'hF; sym = 8'h1B; ctx_clr = '0; rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("rr%0d gnt", c), 32'(gnt), (c % 2 == 0) ? (32'(1) << ((c / 2) % 4)) : 32'(0));
      chk($sformatf("rr%0d out_valid", c), 32'(out_valid), 32'(c % 2 == 0 && c > 0));
      if (c % 2 == 0 && c > 0) chk($sformatf("rr%0d out_ch", c), 32'(out_ch), 32'(((c / 2) - 1) % 4));
      step();
    end
    req = 4'h0;
    @(negedge clk);
    chk("rr tail out_valid", 32'(out_valid), 32'(1));
    chk("rr tail out_ch", 32'(out_ch), 32'(3));
    step();

`ifdef FSM_CTX_SCHED_BACKPRESSURE_EN
    req = 4'h1; sym = 8'h01;
    @(negedge clk);
    chk("bp gnt", 32'(gnt), 32'(1));
    step();
    out_ready = 1'b0; req = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d gnt", c), 32'(gnt), 32'(0));
      chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'(0));
      chk($sformatf("bp%0d core_i", c), 32'(core_i), 32'(1));
      step();
    end
    out_ready = 1'b1; req = 4'h0;
    @(negedge clk);
    chk("bp release core_i", 32'(core_i), 32'(1));
    step();
    @(negedge clk);
    chk("bp done out_valid", 32'(out_valid), 32'(1));
    chk("bp done out_ch", 32'(out_ch), 32'(0));
    step();
`endif

    // Randomised traffic against the reference model.
    rst = 1'b1; req = '0; ctx_clr = '0;
    step(); step();
    model_reset();
    hold = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      req = 4'($urandom);
      for (int k = 0; k < NCH; k++) begin
        if (!hold[k]) sym[2*k +: 2] = 2'($urandom);
        ctx_clr[k] = ($urandom_range(0, 7) == 0);
      end
`ifdef FSM_CTX_SCHED_BACKPRESSURE_EN
      out_ready = ($urandom_range(0, 9) < 7);
`endif
      model_pick();
      e_gnt = (m_w >= 0) ? 4'(1 << m_w) : 4'h0;
      @(negedge clk);
      chk($sformatf("rnd%0d gnt", cyc), 32'(gnt), 32'(e_gnt));
      chk($sformatf("rnd%0d core_s", cyc), 32'(core_s), m_busy ? 32'(m_ctx[m_ch]) : 32'(0));
      chk($sformatf("rnd%0d core_i", cyc), 32'(core_i), m_busy ? 32'(m_sym) : 32'(0));
      chk($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk($sformatf("rnd%0d out_ch", cyc), 32'(out_ch), 32'(m_och));
        chk($sformatf("rnd%0d out_y", cyc), 32'(out_y), 32'(m_oy));
      end
      for (int k = 0; k < NCH; k++) hold[k] = req[k] && !e_gnt[k] && !rst;
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
